// File: rtl/lap_stats_pkg.sv
// Shared encodings and helpers for the lap statistics block.
package lap_stats_pkg;

   // Display mode encodings
   localparam logic [1:0] MODE_LAST = 2'd0;
   localparam logic [1:0] MODE_MIN  = 2'd1;
   localparam logic [1:0] MODE_MAX  = 2'd2;
   localparam logic [1:0] MODE_AVG  = 2'd3;

   // Largest value a 2-digit BCD sample can hold
   localparam logic [6:0] BCD_MAX = 7'd99;

   // Divider sequencing states
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DIV  = 2'd1;
   localparam logic [1:0] CONV = 2'd2;

   // Binary 0..99 to two BCD digits
   function automatic logic [7:0] bin7_to_bcd8(input logic [6:0] b);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(b / 7'd10);
      ones = 4'(b % 7'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// start latches the operands; done is high during the cycle whose closing
// edge performs the final step, so quotient is complete right after it.
module seq_divider #(
   parameter int unsigned DVD_W = 15,
   parameter int unsigned DVS_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             abort,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int unsigned CW = $clog2(DVD_W + 1);

   logic [DVD_W-1:0] quo_q, quo_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DVS_W:0]   trial;
   logic [DVS_W:0]   diff;

   // One restoring step per cycle while the step counter is non-zero
   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      trial = {rem_q, quo_q[DVD_W-1]};
      diff  = trial - {1'b0, dvs_q};
      if (abort) begin
         cnt_d = '0;
      end else if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = CW'(DVD_W);
      end else if (cnt_q != '0) begin
         if (trial >= {1'b0, dvs_q}) begin
            rem_d = diff[DVS_W-1:0];
            quo_d = {quo_q[DVD_W-2:0], 1'b1};
         end else begin
            rem_d = trial[DVS_W-1:0];
            quo_d = {quo_q[DVD_W-2:0], 1'b0};
         end
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Divider state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign busy     = (cnt_q != '0);
   assign done     = (cnt_q == CW'(1));
   assign quotient = quo_q;

endmodule

// File: rtl/lap_stats.sv
// Lap statistics: last/min/max/average of BCD lap samples, one shown on the
// display as BCD, chosen by a cycling mode.
module lap_stats
   import lap_stats_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned SUM_W = 7 + CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       sample_in,
   input  logic             sample_in_valid,
   input  logic             clear,
   input  logic             mode_next,
   output logic [7:0]       stat_out,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             full,
   output logic             bcd_err
);

   logic [6:0]       last_q, last_d, min_q, min_d, max_q, max_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       avg_q, avg_d, stat_q, stat_d;
   logic [1:0]       mode_q, mode_d, state_q, state_d;
   logic             bcd_err_q, bcd_err_d, pending_q, pending_d, acc_q, acc_d;

   logic [3:0]       hi, lo;
   logic             nib_ok, accept, div_start, div_busy, div_done;
   logic [6:0]       bin, quo7;
   logic [SUM_W-1:0] quo;

   assign hi     = sample_in[7:4];
   assign lo     = sample_in[3:0];
   assign nib_ok = (hi <= 4'd9) && (lo <= 4'd9);
   assign full   = (count_q == '1);
   assign accept = sample_in_valid && !clear && nib_ok && !full;
   assign bin    = ({3'b000, hi} * 7'd10) + {3'b000, lo};

   // Statistic accumulation, error flag and display mode
   always_comb begin
      last_d    = last_q;
      min_d     = min_q;
      max_d     = max_q;
      sum_d     = sum_q;
      count_d   = count_q;
      bcd_err_d = bcd_err_q;
      acc_d     = accept;
      mode_d    = mode_next ? mode_q + 2'd1 : mode_q;
      if (clear) begin
         last_d    = '0;
         min_d     = BCD_MAX;
         max_d     = '0;
         sum_d     = '0;
         count_d   = '0;
         bcd_err_d = 1'b0;
      end else if (sample_in_valid) begin
         if (!nib_ok) begin
            bcd_err_d = 1'b1;
         end else if (!full) begin
            last_d  = bin;
            min_d   = (bin < min_q) ? bin : min_q;
            max_d   = (bin > max_q) ? bin : max_q;
            sum_d   = sum_q + SUM_W'(bin);
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Quotient is mathematically <= 99; the clamp only keeps all bits in use
   assign quo7 = (quo > SUM_W'(BCD_MAX)) ? BCD_MAX : quo[6:0];

   // Divider sequencing; an accept during a divide re-runs it on fresh totals
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      avg_d     = avg_q;
      div_start = 1'b0;
      if (clear) begin
         state_d   = IDLE;
         pending_d = 1'b0;
         avg_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (acc_q) begin
                  state_d   = DIV;
                  div_start = 1'b1;
               end
            end
            DIV: begin
               if (acc_q) pending_d = 1'b1;
               if (div_done) state_d = CONV;
            end
            CONV: begin
               avg_d = bin7_to_bcd8(quo7);
               if (pending_q || acc_q) begin
                  state_d   = DIV;
                  div_start = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered display value; nothing is shown until a sample exists
   always_comb begin
      stat_d = '0;
      if (count_q != '0) begin
         case (mode_q)
            MODE_LAST: stat_d = bin7_to_bcd8(last_q);
            MODE_MIN:  stat_d = bin7_to_bcd8(min_q);
            MODE_MAX:  stat_d = bin7_to_bcd8(max_q);
            default:   stat_d = avg_q;
         endcase
      end
   end

   // All block state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q    <= '0;
         min_q     <= BCD_MAX;
         max_q     <= '0;
         sum_q     <= '0;
         count_q   <= '0;
         avg_q     <= '0;
         stat_q    <= '0;
         mode_q    <= MODE_LAST;
         state_q   <= IDLE;
         bcd_err_q <= 1'b0;
         pending_q <= 1'b0;
         acc_q     <= 1'b0;
      end else begin
         last_q    <= last_d;
         min_q     <= min_d;
         max_q     <= max_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         avg_q     <= avg_d;
         stat_q    <= stat_d;
         mode_q    <= mode_d;
         state_q   <= state_d;
         bcd_err_q <= bcd_err_d;
         pending_q <= pending_d;
         acc_q     <= acc_d;
      end
   end

   seq_divider #(
      .DVD_W (SUM_W),
      .DVS_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .abort    (clear),
      .start    (div_start),
      .dividend (sum_q),
      .divisor  (count_q),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quo)
   );

   assign stat_out = stat_q;
   assign mode     = mode_q;
   assign count    = count_q;
   assign busy     = (state_q != IDLE) || pending_q || div_busy;
   assign bcd_err  = bcd_err_q;

endmodule

// File: tb/tb_lap_stats.sv
// Directed bench for lap_stats with hand-computed expectations.
module tb_lap_stats;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sample_in;
   logic       sample_in_valid;
   logic       clear;
   logic       mode_next;
   logic [7:0] stat_out;
   logic [1:0] mode;
   logic [7:0] count;
   logic       busy;
   logic       full;
   logic       bcd_err;

   int total = 0;
   int bad   = 0;
   logic [1:0] exp_mode = 2'd0;

   lap_stats #(.CNT_W(8), .SUM_W(15)) dut (
      .clk             (clk),
      .reset           (reset),
      .sample_in       (sample_in),
      .sample_in_valid (sample_in_valid),
      .clear           (clear),
      .mode_next       (mode_next),
      .stat_out        (stat_out),
      .mode            (mode),
      .count           (count),
      .busy            (busy),
      .full            (full),
      .bcd_err         (bcd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] s);
      sample_in       = s;
      sample_in_valid = 1'b1;
      tick();
      sample_in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic pulse_mode();
      mode_next = 1'b1;
      tick();
      mode_next = 1'b0;
      exp_mode  = exp_mode + 2'd1;
   endtask

   task automatic show(input string tag, input logic [7:0] exp_stat);
      pulse_mode();
      tick();
      chk({tag, "_mode"}, {14'd0, mode}, {14'd0, exp_mode});
      chk(tag, {8'd0, stat_out}, {8'd0, exp_stat});
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      chk("idle_timeout", {15'd0, busy}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int drops;
      reset           = 1'b0;
      sample_in       = 8'h00;
      sample_in_valid = 1'b0;
      clear           = 1'b0;
      mode_next       = 1'b0;
      #1;
      chk("rst_stat",  {8'd0, stat_out}, 16'h0000);
      chk("rst_mode",  {14'd0, mode},    16'd0);
      chk("rst_count", {8'd0, count},    16'd0);
      chk("rst_busy",  {15'd0, busy},    16'd0);
      chk("rst_full",  {15'd0, full},    16'd0);
      chk("rst_err",   {15'd0, bcd_err}, 16'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // three spaced samples: 23 + 57 + 11 = 91, avg 30
      send(8'h23); repeat (30) tick();
      send(8'h57); repeat (30) tick();
      send(8'h11); repeat (30) tick();
      chk("t1_last",  {8'd0, stat_out}, 16'h0011);
      chk("t1_count", {8'd0, count},    16'd3);
      chk("t1_busy",  {15'd0, busy},    16'd0);
      show("t1_min", 8'h11);
      show("t1_max", 8'h57);
      show("t1_avg", 8'h30);
      show("t1_last2", 8'h11);

      // illegal nibble then clear
      send(8'h1A);
      tick();
      chk("t2_err",   {15'd0, bcd_err}, 16'd1);
      chk("t2_count", {8'd0, count},    16'd3);
      chk("t2_last",  {8'd0, stat_out}, 16'h0011);
      pulse_clear();
      chk("t2_err_clr", {15'd0, bcd_err}, 16'd0);
      chk("t2_cnt_clr", {8'd0, count},    16'd0);
      chk("t2_full",    {15'd0, full},    16'd0);
      tick();
      chk("t2_e_last", {8'd0, stat_out}, 16'h0000);
      show("t2_e_min", 8'h00);
      show("t2_e_max", 8'h00);
      show("t2_e_avg", 8'h00);
      show("t2_e_lst", 8'h00);

      // back-to-back samples: second lands while dividing; 31/2 = 15
      send(8'h10);
      send(8'h21);
      chk("t3_busy0", {15'd0, busy}, 16'd1);
      drops = 0;
      repeat (30) begin
         tick();
         if (!busy) drops++;
      end
      chk("t3_busy_hold", 16'(drops), 16'd0);
      wait_idle(40);
      chk("t3_count", {8'd0, count}, 16'd2);
      show("t3_min", 8'h10);
      show("t3_max", 8'h21);
      show("t3_avg", 8'h15);

      // reset in the middle of a divide
      send(8'h33);
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      exp_mode = 2'd0;
      chk("t4_mode",  {14'd0, mode},    16'd0);
      chk("t4_count", {8'd0, count},    16'd0);
      chk("t4_busy",  {15'd0, busy},    16'd0);
      chk("t4_stat",  {8'd0, stat_out}, 16'h0000);
      chk("t4_err",   {15'd0, bcd_err}, 16'd0);
      #1 reset = 1'b1;
      tick();
      repeat (3) pulse_mode();
      chk("t4_avgmode", {14'd0, mode}, 16'd3);
      send(8'h42);
      repeat (17) tick();
      chk("t4_avg_early", {8'd0, stat_out}, 16'h0000);
      chk("t4_idle",      {15'd0, busy},    16'd0);
      tick();
      chk("t4_avg", {8'd0, stat_out}, 16'h0042);

      // saturation: 256 samples of 05
      pulse_clear();
      sample_in       = 8'h05;
      sample_in_valid = 1'b1;
      repeat (256) tick();
      sample_in_valid = 1'b0;
      chk("t5_count", {8'd0, count},    16'd255);
      chk("t5_full",  {15'd0, full},    16'd1);
      chk("t5_err",   {15'd0, bcd_err}, 16'd0);
      wait_idle(100);
      tick();
      chk("t5_avg", {8'd0, stat_out}, 16'h0005);

      // clear together with a sample, then clear together with mode_next
      pulse_clear();
      send(8'h05);
      send(8'h07);
      wait_idle(60);
      chk("t6_count2", {8'd0, count}, 16'd2);
      sample_in       = 8'h09;
      sample_in_valid = 1'b1;
      clear           = 1'b1;
      tick();
      sample_in_valid = 1'b0;
      clear           = 1'b0;
      chk("t6_count0", {8'd0, count},  16'd0);
      chk("t6_mode",   {14'd0, mode},  16'd3);
      chk("t6_busy",   {15'd0, busy},  16'd0);
      tick();
      chk("t6_stat", {8'd0, stat_out}, 16'h0000);
      send(8'h12);
      tick();
      clear     = 1'b1;
      mode_next = 1'b1;
      tick();
      clear     = 1'b0;
      mode_next = 1'b0;
      chk("t6b_count", {8'd0, count}, 16'd0);
      chk("t6b_mode",  {14'd0, mode}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
